// File: rtl/digitube_scan_ctrl_if.sv
// Display-side bus for digitube_scan_ctrl: register-facing inputs and
// board-facing scanned/static segment outputs, sized by DIGITS.
interface digitube_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp_n;
    logic [7*DIGITS-1:0]   digi_flat;
    logic                  frame;

    modport master (
        output en, load, value, dp,
        input  an, seg, dp_n, digi_flat, frame
    );

    modport slave (
        input  en, load, value, dp,
        output an, seg, dp_n, digi_flat, frame
    );
endinterface

// File: rtl/digitube_scan_ctrl.sv
// Self-timed seven-segment scan driver with frame-synchronous display update.
// Define DIGITUBE_LZB_EN to enable leading-zero blanking.
module digitube_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    digitube_scan_ctrl_if.slave   bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [DIGITS-1:0][3:0]  disp;
    logic [DIGITS-1:0][3:0]  pend;
    logic [DIGITS-1:0]       dpd;
    logic [DIGITS-1:0]       pend_dp;
    logic                    pend_valid;
    logic                    slot_end;
    logic                    boundary;
    logic                    past_blank;
    logic                    lit;
    logic [DIGITS-1:0]       an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [7*DIGITS-1:0]     flat_next;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign slot_end = (cnt == CW'(DIV - 1));
    assign boundary = slot_end && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= boundary ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Loads park in pend; disp only changes at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp       <= '0;
            dpd        <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (bus.load) begin
                disp <= bus.value;
                dpd  <= bus.dp;
            end else if (pend_valid) begin
                disp <= pend;
                dpd  <= pend_dp;
            end
        end else if (bus.load) begin
            pend       <= bus.value;
            pend_dp    <= bus.dp;
            pend_valid <= 1'b1;
        end
    end

    generate
        if (BLANK == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (cnt >= CW'(BLANK));
        end
    endgenerate

`ifdef DIGITUBE_LZB_EN
    logic [DIGITS-1:0] dark;
    logic              zero_run;
    logic              dp_seen;

    // Walk down from the most significant digit; a decimal point stops blanking below it.
    always_comb begin
        dark     = '0;
        zero_run = 1'b1;
        dp_seen  = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (disp[i] == 4'h0);
            dp_seen  = dp_seen || dpd[i];
            dark[i]  = zero_run && !dp_seen;
        end
    end

    assign lit = bus.en && past_blank && !dark[idx];
`else
    assign lit = bus.en && past_blank;
`endif

    always_comb begin
        an_next   = '1;
        seg_next  = 7'h7F;
        dp_next   = 1'b1;
        flat_next = '1;
        if (lit) begin
            an_next[idx]          = 1'b0;
            seg_next              = decode(disp[idx]);
            dp_next               = ~dpd[idx];
            flat_next[idx*7 +: 7] = seg_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.an        <= '1;
            bus.seg       <= 7'h7F;
            bus.dp_n      <= 1'b1;
            bus.digi_flat <= '1;
            bus.frame     <= 1'b0;
        end else begin
            bus.an        <= an_next;
            bus.seg       <= seg_next;
            bus.dp_n      <= dp_next;
            bus.digi_flat <= flat_next;
            bus.frame     <= boundary;
        end
    end
endmodule

// File: tb/tb_digitube_scan_ctrl.sv
// Self-checking bench for digitube_scan_ctrl: a cycle-count based reference
// model predicts every registered output; directed steps then random traffic.
module tb_digitube_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;
    localparam int FRAME  = DIGITS * DIV;

    logic clk = 1'b0;
    logic reset;

    digitube_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    digitube_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int passed      = 0;
    int frame_seen  = 0;
    bit cur_en      = 1'b1;

    int                  t;
    logic [4*DIGITS-1:0] m_disp;
    logic [4*DIGITS-1:0] m_pend;
    logic [DIGITS-1:0]   m_dpd;
    logic [DIGITS-1:0]   m_pend_dp;
    bit                  m_pend_valid;

    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    endtask

    function automatic bit digit_shown(input int slot);
`ifdef DIGITUBE_LZB_EN
        return (slot == 0) || ((m_disp >> (4 * slot)) != 0) || ((m_dpd >> slot) != 0);
`else
        return 1'b1;
`endif
    endfunction

    // One clock: drive inputs, predict outputs from the model, step, compare, advance the model.
    task automatic applyStimulus(input bit rst, input bit ld, input logic [4*DIGITS-1:0] val,
                                 input logic [DIGITS-1:0] dpv);
        logic [DIGITS-1:0]   exp_an;
        logic [6:0]          exp_seg;
        logic                exp_dpn;
        logic [7*DIGITS-1:0] exp_flat;
        logic                exp_frame;
        int                  phase;
        int                  slot;
        bit                  vis;
        reset     = rst;
        bus.load  = ld;
        bus.value = val;
        bus.dp    = dpv;
        bus.en    = cur_en;
        exp_an    = '1;
        exp_seg   = 7'h7F;
        exp_dpn   = 1'b1;
        exp_flat  = '1;
        exp_frame = 1'b0;
        if (!rst) begin
            phase = t % DIV;
            slot  = (t / DIV) % DIGITS;
            vis   = cur_en && (phase >= BLANK) && digit_shown(slot);
            if (vis) begin
                exp_an[slot]         = 1'b0;
                exp_seg              = seg_lut[(m_disp >> (4 * slot)) & 4'hF];
                exp_dpn              = ~m_dpd[slot];
                exp_flat[7*slot +: 7] = exp_seg;
            end
            exp_frame = ((t % FRAME) == FRAME - 1);
        end
        @(posedge clk);
        #1;
        checkOutput("an", 64'(bus.an), 64'(exp_an));
        checkOutput("seg", 64'(bus.seg), 64'(exp_seg));
        checkOutput("dp_n", 64'(bus.dp_n), 64'(exp_dpn));
        checkOutput("digi_flat", 64'(bus.digi_flat), 64'(exp_flat));
        checkOutput("frame", 64'(bus.frame), 64'(exp_frame));
        if (bus.frame === 1'b1) frame_seen++;
        if (rst) begin
            t            = 0;
            m_disp       = '0;
            m_dpd        = '0;
            m_pend       = '0;
            m_pend_dp    = '0;
            m_pend_valid = 1'b0;
        end else begin
            if ((t % FRAME) == FRAME - 1) begin
                if (ld) begin
                    m_disp = val;
                    m_dpd  = dpv;
                end else if (m_pend_valid) begin
                    m_disp = m_pend;
                    m_dpd  = m_pend_dp;
                end
                m_pend_valid = 1'b0;
            end else if (ld) begin
                m_pend       = val;
                m_pend_dp    = dpv;
                m_pend_valid = 1'b1;
            end
            t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle_until_phase(input int frame_pos);
        for (int i = 0; i < FRAME && (t % FRAME) != frame_pos; i++) applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        t = 0;
        m_disp = '0; m_dpd = '0; m_pend = '0; m_pend_dp = '0; m_pend_valid = 1'b0;
        $display("[TB] start DIGITS=%0d DIV=%0d BLANK=%0d", DIGITS, DIV, BLANK);

        // Reset, then the blank/visible pattern of slot 0
        applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("an_after_reset", 64'(bus.an), 64'h0F);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("an_slot0_first", 64'(bus.an), 64'hE);
        checkOutput("seg_zero", 64'(bus.seg), 64'h40);
        frame_seen = 0;
        idle(62);
        checkOutput("frame_count", 64'(frame_seen), 64'd4);

        // Mid-frame load shows only from the next frame
        idle_until_phase(5);
        applyStimulus(1'b0, 1'b1, 16'h12AF, 4'b0100);
        idle(2 * FRAME);

        // Two loads in one frame: last wins
        idle_until_phase(2);
        applyStimulus(1'b0, 1'b1, 16'h1111, 4'b0000);
        idle(3);
        applyStimulus(1'b0, 1'b1, 16'h2222, 4'b0000);
        idle(2 * FRAME);

        // Load exactly on the boundary cycle bypasses pend
        idle_until_phase(FRAME - 1);
        applyStimulus(1'b0, 1'b1, 16'h3C5E, 4'b0001);
        checkOutput("bypass_frame", 64'(bus.frame), 64'd1);
        idle(2);
        checkOutput("bypass_seg", 64'(bus.seg), 64'h06);
        checkOutput("bypass_dp", 64'(bus.dp_n), 64'd0);
        idle(FRAME);

        // Display disable window mid-scan
        idle_until_phase(6);
        cur_en = 1'b0;
        idle(10);
        checkOutput("en_off_flat", 64'(bus.digi_flat), 64'hFFF_FFFF);
        cur_en = 1'b1;
        idle(FRAME);

        // Reset mid-frame discards a pending load
        idle_until_phase(3);
        applyStimulus(1'b0, 1'b1, 16'h9876, 4'b1111);
        idle(2);
        applyStimulus(1'b1, 1'b0, '0, '0);
        idle(2 * FRAME);

        // Leading-zero patterns
        applyStimulus(1'b0, 1'b1, 16'h0050, 4'b0000);
        idle(2 * FRAME);
        applyStimulus(1'b0, 1'b1, 16'h0050, 4'b1000);
        idle(2 * FRAME);
        applyStimulus(1'b0, 1'b1, 16'h0007, 4'b0010);
        idle(2 * FRAME);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) cur_en = ~cur_en;
            if ($urandom_range(7) == 0)
                applyStimulus(1'b0, 1'b1, 16'($urandom), 4'($urandom));
            else if ($urandom_range(199) == 0)
                applyStimulus(1'b1, 1'b0, '0, '0);
            else
                applyStimulus(1'b0, 1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/digitube_scan_ctrl.md
# digitube_scan_ctrl

Self-timed multiplexing driver for N seven-segment digits. It accepts a packed hex value with per-digit decimal points and generates its own scan sequence, per-digit blanking and hex-to-segment decode. It also provides a de-multiplexed static bus for boards with non-scanned displays (DE2). It sits between the CPU's memory-mapped display register and the board pins.

## Interface
- DIGITS, 4, number of digits scanned (≥2)
- DIV, 50000, clk cycles per digit slot (≥2)
- BLANK, 2, cycles at the start of each slot with all anodes off (0 ≤ BLANK < DIV)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  display enable; low forces all anodes off, counters keep running
- load  in  1  one-cycle strobe: capture value/dp into pending register
- value  in  4*DIGITS  hex nibbles, digit i = value[4i+3:4i], digit 0 = rightmost
- dp  in  DIGITS  decimal point request per digit, active-high
- an  out  DIGITS  anode select, active-low, at most one low
- seg  out  7  CG,CF,CE,CD,CC,CB,CA, active-low
- dp_n  out  1  decimal point segment, active-low
- digi_flat  out  7*DIGITS  static bus, field i = seg while an[i]==0, else 7'h7F
- frame  out  1  one-cycle pulse when the slot index wraps DIGITS-1 → 0

## Operation
- Prescaler cnt counts 0..DIV-1 and wraps. On wrap, slot index idx advances by 1; DIGITS-1 wraps to 0 and raises frame.
- Display register disp/dpd updates only at the frame boundary, so no tearing within a frame. The boundary is the cycle where cnt==DIV-1 and idx==DIGITS-1.
- load sets pend_valid and captures value/dp into pend. A later load before the boundary overwrites pend; the last load wins.
- At the boundary: if load is high that cycle, disp takes the load inputs directly (bypass). Else if pend_valid, disp ← pend. pend_valid clears either way.
- Slot visibility: digit idx is visible when en==1 and cnt ≥ BLANK; otherwise an = all ones.
- When visible: an[idx]=0, seg = decode(disp nibble idx), dp_n = ~dpd[idx]. When not visible: seg=7'h7F, dp_n=1.
- Decode is active-low CG..CA: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Counter widths: cnt $clog2(DIV); idx max(1,$clog2(DIGITS)).

## Timing
- an, seg, dp_n, digi_flat and frame are registered. They reflect cycle-N cnt/idx/disp state at cycle N+1.
- Reset values: an all ones, seg 7'h7F, dp_n 1, digi_flat all ones, frame 0. Internal: cnt 0, idx 0, disp 0, dpd 0, pend_valid 0.
- Reset mid-frame: all state returns to reset values the next cycle and the pending load is discarded.
- After reset deasserts, slot 0 is visible at output from cycle BLANK+1 (cycle 0 = first cycle with reset low).
- A load is shown no earlier than the first slot-0 output of the next frame. Worst-case latency is DIGITS*DIV+1 cycles.
- en toggling takes effect on outputs one cycle later and does not disturb scan phase.

## Configuration
- DIGITUBE_LZB_EN defined: leading-zero blanking is enabled.
  - Digit i>0 stays dark (an[i]=1, field i = 7F) when its nibble and every more-significant nibble are 0.
  - A set dpd bit on digit j disables blanking for digits ≤ j.
  - Digit 0 is always shown.
- DIGITUBE_LZB_EN undefined: all digits are always shown, including zeros.

## Test plan
- Reset, DIGITS=4 DIV=4 BLANK=1, no load → an stays 1111 for cycle 1, then the sequence 1110 (3 cycles), one blank cycle, 1101…; seg=7'h40 in every visible slot; frame pulses every 16 cycles.
- load value=16'h12AF dp=4'b0100 mid-frame → old digits until the next frame; then slot 0 seg=0E, slot 1 seg=08, slot 2 seg=24 with dp_n=0, slot 3 seg=79.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is ever displayed.
- load asserted on the exact boundary cycle → the new value appears in that frame's slot 0 without a one-frame delay.
- en=0 for 10 cycles mid-scan → an=1111 and digi_flat all ones during the window; frame pulse timing is unchanged.
- With DIGITUBE_LZB_EN and value=16'h0050, dp=0 → digits 3,2 dark, digits 1,0 show 12,40. With dp=4'b1000 → all four digits are shown.
